iter_shift32: RTL
=================

// Module: iter_shift32
// PURPOSE
//   Multi-cycle 32-bit shift unit for the processor ALU path.
//   Shifts left or right by STEP bits per clock, with a START/DONE handshake.
//   Area-lean alternative to the combinational left/right barrel shifters.
//   Same D/S/Y operand convention, so the ALU can select either implementation.
// PARAMETERS
//   STEP   4   bits shifted per BUSY cycle; one of 1, 2, 4, 8, 16
// PORTS
//   CLK     in   1   single clock, rising edge
//   RST     in   1   asynchronous reset, active-low
//   START   in   1   request; sampled only in IDLE or DONE
//   DIR     in   1   0 = shift left (zero fill), 1 = shift right
//   D       in   32  operand, captured on the accepted START
//   S       in   5   shift amount 0..31, captured on the accepted START
//   Y       out  32  result; holds its value until the next DONE
//   BUSY    out  1   high while a shift is in progress
//   DONE    out  1   one-cycle pulse; Y is valid in the same cycle
// BEHAVIOUR
//   Reset (RST=0, any time, including mid-shift): state=IDLE, Y=0, BUSY=0,
//     DONE=0, work regs=0. The in-flight operation is discarded.
//   FSM states: IDLE, SHIFT, FIN.
//   IDLE/FIN with START=1:
//     capture D -> sh, S -> cnt, DIR.
//     If S==0, next state is FIN; otherwise next state is SHIFT.
//   IDLE with START=0: stay in IDLE.
//   FIN with START=0: next state is IDLE.
//   Accepting START in FIN gives back-to-back operations with no idle cycle.
//   SHIFT, each cycle:
//     k = min(STEP, cnt); sh <= sh shifted by k in DIR; cnt <= cnt - k.
//     If cnt - k == 0, next state is FIN.
//     START is ignored in SHIFT (no queueing; D/S/DIR changes have no effect).
//   On entry to FIN: Y <= sh.
//   In FIN: DONE=1, BUSY=0. In SHIFT: BUSY=1.
//   Latency: DONE is high exactly ceil(S/STEP)+1 cycles after the START edge.
//     S=0 gives latency 1.
//   Width: cnt is 5 bits. Bits shifted out are dropped.
//     Left shift fills with 0. Right shift fills with 0 (see CONFIGURATION).
//   Y changes only on FIN entry or reset.
// CONFIGURATION
//   SHIFT_ARITH_EN defined:
//     adds input port ARITH (1 bit), captured with START.
//     DIR=1 with ARITH=1 fills from bit 31 of the captured D (arithmetic right).
//     ARITH is ignored when DIR=0.
//   SHIFT_ARITH_EN undefined:
//     no ARITH port; right shifts are always logical.
// STRUCTURE
//   Shared package shift_pkg:
//     FSM state encodings (2 bits).
//     DIR_LEFT / DIR_RIGHT constants.
//     Legal STEP values, checked by an elaboration-time assertion.
//   Sub-module shift_stage: combinational one-step shifter.
//     Inputs: sh, k (0..STEP), DIR, fill bit. Output: the shifted value.
//   Top level holds the FSM, cnt, sh and the Y register.
// TESTING
//   1. Left sweep, STEP=4: D=0x0000_0001, S=0..31 -> Y=1<<S;
//      DONE after ceil(S/4)+1 cycles (S=31 -> Y=0x8000_0000 at 9 cycles).
//   2. Right sweep: D=0x8000_0000, DIR=1, S=0..31 -> Y=0x8000_0000>>S;
//      S=0 -> DONE in 1 cycle, Y=0x8000_0000.
//   3. Back-to-back: START held high across FIN with D=0xF0, S=4 left,
//      then D=0xF0, S=4 right -> Y=0xF00, then Y=0x0F;
//      no IDLE cycle between the two DONE pulses.
//   4. START pulsed again during SHIFT with different D/S -> ignored;
//      the first result is still produced with unchanged latency.
//   5. RST driven low during SHIFT (D=1, S=31) -> BUSY=0, DONE=0 and Y=0
//      immediately; after release, a new START with D=1, S=1 -> Y=2.
//   6. SHIFT_ARITH_EN: D=0x8000_0000, DIR=1, ARITH=1, S=4 -> Y=0xF800_0000;
//      same with ARITH=0 -> Y=0x0800_0000.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the iterative 32-bit shifter: FSM encodings,
// direction constants and the legal-STEP helper used at elaboration.
package shift_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StFin   = 2'd2
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Only power-of-two steps up to 16 keep k within the 5-bit count range.
  function automatic bit step_legal(int unsigned step);
    return (step == 1) || (step == 2) || (step == 4) || (step == 8) || (step == 16);
  endfunction

endpackage

// File: rtl/iter_shift32_if.sv
// Request/result bundle of iter_shift32. The optional arith input exists only
// when SHIFT_ARITH_EN is defined.
interface iter_shift32_if;
  logic        start;
  logic        dir;
  logic [31:0] d;
  logic [4:0]  s;
  logic [31:0] y;
  logic        busy;
  logic        done;
`ifdef SHIFT_ARITH_EN
  logic        arith;

  modport master (output start, dir, d, s, arith, input y, busy, done);
  modport slave  (input start, dir, d, s, arith, output y, busy, done);
`else
  modport master (output start, dir, d, s, input y, busy, done);
  modport slave  (input start, dir, d, s, output y, busy, done);
`endif
endinterface

// File: rtl/shift_stage.sv
// Combinational one-step shifter: moves sh by k bits in dir, filling vacated
// high bits with fill on right shifts and zeros on left shifts.
module shift_stage
  import shift_pkg::*;
(
  input  logic [31:0] sh,
  input  logic [4:0]  k,
  input  logic        dir,
  input  logic        fill,
  output logic [31:0] shifted
);

  logic [31:0] fill_mask;

  // Shift by k; the mask covers exactly the k vacated top bits.
  always_comb begin
    fill_mask = fill ? ~(32'hFFFF_FFFF >> k) : 32'h0;
    if (dir == DIR_LEFT) begin
      shifted = sh << k;
    end else begin
      shifted = (sh >> k) | fill_mask;
    end
  end

endmodule

// File: rtl/iter_shift32.sv
// Multi-cycle 32-bit shifter, STEP bits per cycle, START/DONE handshake.
// Optional feature: define SHIFT_ARITH_EN to add the arith input
// (arithmetic right shift filling from bit 31 of the captured operand).
module iter_shift32
  import shift_pkg::*;
#(
  parameter int unsigned STEP = 4
) (
  input logic           clk,
  input logic           rst_n,
  iter_shift32_if.slave bus
);

  if (!step_legal(STEP)) begin : g_bad_step
    $error("iter_shift32: STEP must be 1, 2, 4, 8 or 16");
  end

  localparam logic [4:0] StepK = 5'(STEP);

  state_e      state_q;
  logic [31:0] sh_q;
  logic [31:0] y_q;
  logic [4:0]  cnt_q;
  logic        dir_q;
  logic        fill_q;
  logic        busy_q;
  logic        done_q;

  logic [4:0]  k;
  logic [4:0]  cnt_next;
  logic [31:0] shifted;
  logic        fill_in;

  // Per-cycle step size and remaining count; fill bit taken from the new request.
  always_comb begin
    k        = (cnt_q < StepK) ? cnt_q : StepK;
    cnt_next = cnt_q - k;
`ifdef SHIFT_ARITH_EN
    fill_in  = bus.arith & (bus.dir == DIR_RIGHT) & bus.d[31];
`else
    fill_in  = 1'b0;
`endif
  end

  shift_stage u_stage (
    .sh      (sh_q),
    .k       (k),
    .dir     (dir_q),
    .fill    (fill_q),
    .shifted (shifted)
  );

  // FSM with registered busy/done; y loads only when entering StFin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sh_q    <= 32'h0;
      y_q     <= 32'h0;
      cnt_q   <= 5'h0;
      dir_q   <= DIR_LEFT;
      fill_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StFin: begin
          if (bus.start) begin
            sh_q   <= bus.d;
            cnt_q  <= bus.s;
            dir_q  <= bus.dir;
            fill_q <= fill_in;
            if (bus.s == 5'd0) begin
              state_q <= StFin;
              y_q     <= bus.d;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= StShift;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end else begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        StShift: begin
          sh_q  <= shifted;
          cnt_q <= cnt_next;
          if (cnt_next == 5'd0) begin
            state_q <= StFin;
            y_q     <= shifted;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.y    = y_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
